image_buffer_writer: RTL and testbench

//  Streaming front end that fills the FC1 input-image buffer: accepts one pixel per valid/ready beat,

---
 rtl/mnist_pkg.sv | 26 ++
 rtl/image_buffer_writer.sv | 140 ++++++++++++++
 tb/tb_image_buffer_writer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mnist_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mnist_pkg
//  Description : Shared sizes, writer state encoding and the pixel-to-int8
//                quantiser for the FC1 input-image loader.
//  Revision    : 1.0  initial release
// ============================================================================
package mnist_pkg;

    localparam int IN1   = 784;
    localparam int PIX_W = 8;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_COMMIT = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    // Unsigned pixels are halved into 0..127 so they stay positive as int8.
    function automatic logic [PIX_W-1:0] pix_to_int8(input logic [PIX_W-1:0] pix,
                                                     input logic             signed_in);
        return signed_in ? pix : {1'b0, pix[PIX_W-1:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/image_buffer_writer.sv
`default_nettype none
// ============================================================================
//  Module      : image_buffer_writer
//  Description : Accepts one pixel per valid/ready beat, quantises it to int8
//                and writes it into x_mem through a registered write port.
//                Pulses frame_done after a full frame, then stalls the stream
//                until frame_release so the buffer is stable during inference.
//  Revision    : 1.0  initial release
// ============================================================================
module image_buffer_writer
    import mnist_pkg::*;
#(
    parameter int   IN_DIM    = IN1,
    parameter bit   IN_SIGNED = 1'b0,
    localparam int  AW        = $clog2(IN_DIM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [PIX_W-1:0] s_data_i,
    input  logic             s_last_i,
    output logic             x_we_o,
    output logic [AW-1:0]    x_addr_o,
    output logic [PIX_W-1:0] x_data_o,
    output logic             frame_done_o,
    input  logic             frame_release_i,
    output logic             len_err_o
);

    localparam logic [AW-1:0] LAST_IDX = AW'(IN_DIM - 1);

    state_t           state_q,      state_d;
    logic [AW-1:0]    pix_cnt_q,    pix_cnt_d;
    logic             drain_q,      drain_d;     // swallowing a long frame's surplus beats
    logic             s_ready_q,    s_ready_d;
    logic             x_we_q,       x_we_d;
    logic [AW-1:0]    x_addr_q,     x_addr_d;
    logic [PIX_W-1:0] x_data_q,     x_data_d;
    logic             frame_done_q, frame_done_d;
    logic             len_err_q,    len_err_d;

    logic             w_accept;
    logic             w_at_last;

    assign w_accept  = s_valid_i & s_ready_q;
    assign w_at_last = (pix_cnt_q == LAST_IDX);

    // Next-state, counter and write-port decode.
    always_comb begin
        state_d      = state_q;
        pix_cnt_d    = pix_cnt_q;
        drain_d      = drain_q;
        x_we_d       = 1'b0;
        x_addr_d     = x_addr_q;
        x_data_d     = x_data_q;
        frame_done_d = 1'b0;
        len_err_d    = 1'b0;

        unique case (state_q)
            S_LOAD: begin
                if (w_accept) begin
                    x_we_d   = 1'b1;
                    x_addr_d = pix_cnt_q;
                    x_data_d = pix_to_int8(s_data_i, IN_SIGNED);
                    if (w_at_last) begin
                        state_d   = S_COMMIT;
                        pix_cnt_d = '0;
                        if (!s_last_i) begin
                            // Long frame: keep the sender moving until its s_last.
                            len_err_d = 1'b1;
                            drain_d   = 1'b1;
                        end
                    end else if (s_last_i) begin
                        // Short frame: drop it and restart at address 0.
                        len_err_d = 1'b1;
                        pix_cnt_d = '0;
                    end else begin
                        pix_cnt_d = pix_cnt_q + AW'(1);
                    end
                end
            end
            S_COMMIT: begin
                if (drain_q) begin
                    if (w_accept && s_last_i) begin
                        drain_d = 1'b0;
                    end
                end else begin
                    frame_done_d = 1'b1;
                    state_d      = S_HOLD;
                end
            end
            S_HOLD: begin
                // A release coinciding with frame_done is too early to honour.
                if (frame_release_i && !frame_done_q) begin
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase

        s_ready_d = (state_d == S_LOAD) | drain_d;
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_LOAD;
            pix_cnt_q    <= '0;
            drain_q      <= 1'b0;
            s_ready_q    <= 1'b0;
            x_we_q       <= 1'b0;
            x_addr_q     <= '0;
            x_data_q     <= '0;
            frame_done_q <= 1'b0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            drain_q      <= drain_d;
            s_ready_q    <= s_ready_d;
            x_we_q       <= x_we_d;
            x_addr_q     <= x_addr_d;
            x_data_q     <= x_data_d;
            frame_done_q <= frame_done_d;
            len_err_q    <= len_err_d;
        end
    end

    assign s_ready_o    = s_ready_q;
    assign x_we_o       = x_we_q;
    assign x_addr_o     = x_addr_q;
    assign x_data_o     = x_data_q;
    assign frame_done_o = frame_done_q;
    assign len_err_o    = len_err_q;

endmodule
`default_nettype wire

// File: tb/tb_image_buffer_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_image_buffer_writer
//  Description : Randomised stream bench for image_buffer_writer with a
//                frame-level reference model (expected write list, frame_done
//                and len_err counts, frame_done timing).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_image_buffer_writer;

    localparam int IN_DIM = 784;
    localparam int AW     = $clog2(IN_DIM);

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid, s_last, frame_release;
    logic [7:0]    s_data;
    logic          s_ready, x_we, frame_done, len_err;
    logic [AW-1:0] x_addr;
    logic [7:0]    x_data;

    // Small signed-input instance for the int8 pass-through case.
    logic          v2, l2, rel2;
    logic [7:0]    d2;
    logic          r2, we2, done2, lerr2;
    logic [1:0]    addr2;
    logic [7:0]    xd2;

    int n_checks = 0;
    int n_bad    = 0;
    int cyc      = 0;

    // Reference model state
    int q_addr[$];
    int q_data[$];
    int m_idx        = 0;
    int exp_done     = 0;
    int exp_len      = 0;
    int obs_done     = 0;
    int obs_len      = 0;
    int exp_done_cyc = -1;

    always #5 clk = ~clk;

    image_buffer_writer #(.IN_DIM(IN_DIM), .IN_SIGNED(1'b0)) u_dut (
        .clk(clk), .rst(rst),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data), .s_last_i(s_last),
        .x_we_o(x_we), .x_addr_o(x_addr), .x_data_o(x_data),
        .frame_done_o(frame_done), .frame_release_i(frame_release), .len_err_o(len_err)
    );

    image_buffer_writer #(.IN_DIM(4), .IN_SIGNED(1'b1)) u_dut_s (
        .clk(clk), .rst(rst),
        .s_valid_i(v2), .s_ready_o(r2), .s_data_i(d2), .s_last_i(l2),
        .x_we_o(we2), .x_addr_o(addr2), .x_data_o(xd2),
        .frame_done_o(done2), .frame_release_i(rel2), .len_err_o(lerr2)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d want=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Frame-level model of one accepted beat.
    task automatic model_accept(input logic [7:0] d, input logic last);
        if (m_idx < IN_DIM) begin
            q_addr.push_back(m_idx);
            q_data.push_back(int'(d) / 2);
        end
        if (last && m_idx < IN_DIM - 1) begin
            exp_len++;
            m_idx = 0;
        end else if (!last && m_idx == IN_DIM - 1) begin
            exp_len++;
            m_idx++;
        end else if (last) begin
            exp_done++;
            exp_done_cyc = cyc + 2;
            m_idx = 0;
        end else begin
            m_idx++;
        end
    endtask

    // Advance one clock and check the main instance's outputs after the edge.
    task automatic tick();
        logic acc;
        int   ea, ed;
        acc = s_valid && s_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (!acc) check_eq("we_without_accept", x_we, 1'b0);
        if (x_we) begin
            if (q_addr.size() == 0) begin
                check_eq("unexpected_we", x_we, 1'b0);
            end else begin
                ea = q_addr.pop_front();
                ed = q_data.pop_front();
                check_eq("x_addr", x_addr, ea);
                check_eq("x_data", x_data, ed);
            end
        end
        if (frame_done) begin
            obs_done++;
            check_eq("frame_done_cycle", cyc, exp_done_cyc);
        end
        if (len_err) obs_len++;
    endtask

    task automatic drive_stream(input int n, input int last_pos, input int idle_pct, input bit ramp);
        int k;
        int guard;
        k = 0;
        guard = 0;
        while (k < n && guard < n * 4 + 200) begin
            s_valid = ($urandom_range(99) >= idle_pct);
            s_data  = ramp ? 8'(k % 256) : 8'($urandom);
            s_last  = s_valid ? (k == last_pos) : 1'($urandom);
            if (s_valid && s_ready) begin
                model_accept(s_data, s_last);
                k++;
            end
            tick();
            guard++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        check_eq("stream_beats", k, n);
    endtask

    task automatic end_check();
        repeat (3) tick();
        check_eq("frame_done_count", obs_done, exp_done);
        check_eq("len_err_count", obs_len, exp_len);
        check_eq("pending_writes", q_addr.size(), 0);
    endtask

    task automatic release_frame();
        frame_release = 1'b1;
        tick();
        frame_release = 1'b0;
        check_eq("ready_after_release", s_ready, 1'b1);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_s_ready", s_ready, 1'b0);
        check_eq("rst_x_we", x_we, 1'b0);
        check_eq("rst_x_addr", x_addr, 0);
        check_eq("rst_x_data", x_data, 0);
        check_eq("rst_frame_done", frame_done, 1'b0);
        check_eq("rst_len_err", len_err, 1'b0);
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        s_last  = 1'b0;
        rst     = 1'b1;
        #1;
        check_reset_outputs();
        q_addr.delete();
        q_data.delete();
        m_idx = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_signed();
        logic [7:0] pat [4];
        int         k;
        int         guard;
        logic       acc2;
        pat   = '{8'h80, 8'h7F, 8'h01, 8'hFF};
        k     = 0;
        guard = 0;
        while (k < 4 && guard < 50) begin
            v2   = 1'b1;
            d2   = pat[k];
            l2   = (k == 3);
            acc2 = v2 && r2;
            tick();
            guard++;
            if (acc2) begin
                check_eq("s_we", we2, 1'b1);
                check_eq("s_addr", addr2, k);
                check_eq("s_data", $signed(xd2), $signed(pat[k]));
                k++;
            end
        end
        v2 = 1'b0;
        l2 = 1'b0;
        check_eq("s_beats", k, 4);
        tick();
        check_eq("s_frame_done", done2, 1'b1);
        check_eq("s_ready_hold", r2, 1'b0);
        check_eq("s_len_err", lerr2, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; frame_release = 1'b0;
        v2 = 1'b0; l2 = 1'b0; d2 = 8'h00; rel2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;
        tick();
        check_eq("ready_after_reset", s_ready, 1'b1);

        // Back-to-back ramp frame
        drive_stream(IN_DIM, IN_DIM - 1, 0, 1'b1);
        end_check();
        check_eq("ready_low_in_hold", s_ready, 1'b0);
        release_frame();

        // Same ramp with ~30% idle beats
        drive_stream(IN_DIM, IN_DIM - 1, 30, 1'b1);
        end_check();
        release_frame();

        // Short frame then a full frame
        drive_stream(100, 99, 10, 1'b0);
        end_check();
        drive_stream(IN_DIM, IN_DIM - 1, 10, 1'b0);
        end_check();
        release_frame();

        // Hold-off: early release ignored, 20 cycles of pushing, then release
        drive_stream(IN_DIM, IN_DIM - 1, 0, 1'b0);
        tick();
        frame_release = 1'b1;
        tick();
        frame_release = 1'b0;
        check_eq("release_with_done_ignored", s_ready, 1'b0);
        s_valid = 1'b1;
        s_data  = 8'hAA;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("hold_ready", s_ready, 1'b0);
        end
        s_valid = 1'b0;
        end_check();
        release_frame();

        // Long frame: surplus beats drained before frame_done
        drive_stream(IN_DIM + 2, IN_DIM + 1, 20, 1'b0);
        end_check();
        release_frame();

        // Reset mid-frame, then a clean restart
        drive_stream(400, -1, 0, 1'b0);
        do_reset();
        drive_stream(IN_DIM, IN_DIM - 1, 10, 1'b0);
        end_check();
        release_frame();

        // Signed pass-through instance
        run_signed();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
